// File: rtl/tx_pkt_scheduler.sv
// tx_pkt_scheduler: packet-granular 2:1 AXI4-Stream scheduler.
// Port 0 carries pass-through traffic and port 1 carries generator traffic.
// One whole packet is granted at a time. Port 1 is throttled by an
// inter-packet gap and a burst limit.
// Optional build macro TX_SCHED_STRICT_PRIO_EN: port 0 always wins in IDLE.
// Without the macro, ties are resolved round-robin.
module tx_pkt_scheduler #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_GAP_WIDTH        = 16,
  parameter int C_BURST_WIDTH      = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    S_AXIS_0_TDATA,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_0_TSTRB,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   S_AXIS_0_TUSER,
  input  logic                            S_AXIS_0_TVALID,
  input  logic                            S_AXIS_0_TLAST,
  output logic                            S_AXIS_0_TREADY,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    S_AXIS_1_TDATA,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_1_TSTRB,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   S_AXIS_1_TUSER,
  input  logic                            S_AXIS_1_TVALID,
  input  logic                            S_AXIS_1_TLAST,
  output logic                            S_AXIS_1_TREADY,
  output logic [C_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                            M_AXIS_TVALID,
  output logic                            M_AXIS_TLAST,
  input  logic                            M_AXIS_TREADY,
  input  logic                            cfg_gen_en,
  input  logic [C_GAP_WIDTH-1:0]          cfg_gap,
  input  logic [C_BURST_WIDTH-1:0]        cfg_burst,
  input  logic                            rst_cntrs,
  output logic [31:0]                     pkt_cnt0,
  output logic [31:0]                     pkt_cnt1,
  output logic                            burst_done,
  output logic                            busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_SEND0 = 3'b010,
    ST_SEND1 = 3'b100
  } state_t;

  localparam logic [C_GAP_WIDTH-1:0]   GAP_ZERO   = {C_GAP_WIDTH{1'b0}};
  localparam logic [C_GAP_WIDTH-1:0]   GAP_ONE    = {{(C_GAP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_BURST_WIDTH-1:0] BURST_ZERO = {C_BURST_WIDTH{1'b0}};
  localparam logic [C_BURST_WIDTH-1:0] BURST_ONE  = {{(C_BURST_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic [C_GAP_WIDTH-1:0]   gap_cnt_r;
  logic [C_BURST_WIDTH-1:0] burst_cnt_r;
  logic [C_BURST_WIDTH-1:0] burst_cnt_nxt_s;
  logic                     burst_done_r;
  logic [31:0]              pkt_cnt0_r;
  logic [31:0]              pkt_cnt1_r;
  logic                     busy_r;
  logic                     elig0_s;
  logic                     elig1_s;
  logic                     done0_s;
  logic                     done1_s;

  // A port is eligible when it is valid. Port 1 must also be enabled, outside its gap, and under its burst limit.
  assign elig0_s = S_AXIS_0_TVALID;
  assign elig1_s = S_AXIS_1_TVALID & cfg_gen_en & (gap_cnt_r == GAP_ZERO) & ~burst_done_r;

  // A packet ends on the output TLAST handshake of the port that owns the grant.
  assign done0_s = (state_r == ST_SEND0) & S_AXIS_0_TVALID & S_AXIS_0_TLAST & M_AXIS_TREADY;
  assign done1_s = (state_r == ST_SEND1) & S_AXIS_1_TVALID & S_AXIS_1_TLAST & M_AXIS_TREADY;

`ifndef TX_SCHED_STRICT_PRIO_EN
  logic last_grant_r;

  // Remember which port was granted last so that ties alternate; port 0 wins the first tie.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      last_grant_r <= 1'b1;
    end else if ((state_r == ST_IDLE) && (state_nxt_s != ST_IDLE)) begin
      last_grant_r <= (state_nxt_s == ST_SEND1);
    end
  end
`endif

  // Next-state arbitration: the grant is decided in IDLE and held until the packet's last beat.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
`ifdef TX_SCHED_STRICT_PRIO_EN
        if (elig0_s) begin
          state_nxt_s = ST_SEND0;
        end else if (elig1_s) begin
          state_nxt_s = ST_SEND1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
`else
        if (elig0_s && elig1_s) begin
          state_nxt_s = last_grant_r ? ST_SEND0 : ST_SEND1;
        end else if (elig0_s) begin
          state_nxt_s = ST_SEND0;
        end else if (elig1_s) begin
          state_nxt_s = ST_SEND1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
`endif
      end
      ST_SEND0: begin
        if (done0_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SEND0;
        end
      end
      ST_SEND1: begin
        if (done1_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SEND1;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output mux: the granted port is wired straight through; in IDLE every output is quiet.
  always_comb begin
    M_AXIS_TDATA    = {C_AXIS_DATA_WIDTH{1'b0}};
    M_AXIS_TSTRB    = {(C_AXIS_DATA_WIDTH/8){1'b0}};
    M_AXIS_TUSER    = {C_AXIS_TUSER_WIDTH{1'b0}};
    M_AXIS_TVALID   = 1'b0;
    M_AXIS_TLAST    = 1'b0;
    S_AXIS_0_TREADY = 1'b0;
    S_AXIS_1_TREADY = 1'b0;
    case (state_r)
      ST_SEND0: begin
        M_AXIS_TDATA    = S_AXIS_0_TDATA;
        M_AXIS_TSTRB    = S_AXIS_0_TSTRB;
        M_AXIS_TUSER    = S_AXIS_0_TUSER;
        M_AXIS_TVALID   = S_AXIS_0_TVALID;
        M_AXIS_TLAST    = S_AXIS_0_TLAST;
        S_AXIS_0_TREADY = M_AXIS_TREADY;
      end
      ST_SEND1: begin
        M_AXIS_TDATA    = S_AXIS_1_TDATA;
        M_AXIS_TSTRB    = S_AXIS_1_TSTRB;
        M_AXIS_TUSER    = S_AXIS_1_TUSER;
        M_AXIS_TVALID   = S_AXIS_1_TVALID;
        M_AXIS_TLAST    = S_AXIS_1_TLAST;
        S_AXIS_1_TREADY = M_AXIS_TREADY;
      end
      default: begin
        M_AXIS_TVALID   = 1'b0;
      end
    endcase
  end

  // Burst count: cleared while the generator is disabled, advanced on each completed port-1 packet.
  always_comb begin
    if (!cfg_gen_en) begin
      burst_cnt_nxt_s = BURST_ZERO;
    end else if (done1_s) begin
      burst_cnt_nxt_s = burst_cnt_r + BURST_ONE;
    end else begin
      burst_cnt_nxt_s = burst_cnt_r;
    end
  end

  // State register; async reset drops any packet in flight.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // Gap counter: loaded at each port-1 packet end, then counts down to zero regardless of state.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      gap_cnt_r <= GAP_ZERO;
    end else if (done1_s) begin
      gap_cnt_r <= cfg_gap;
    end else if (gap_cnt_r != GAP_ZERO) begin
      gap_cnt_r <= gap_cnt_r - GAP_ONE;
    end
  end

  // Burst tracking: the flag is taken from the next count so no extra packet slips through.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      burst_cnt_r  <= BURST_ZERO;
      burst_done_r <= 1'b0;
    end else begin
      burst_cnt_r  <= burst_cnt_nxt_s;
      burst_done_r <= (cfg_burst != BURST_ZERO) && (burst_cnt_nxt_s == cfg_burst);
    end
  end

  // Completed-packet counters; a counter clear beats a same-cycle increment.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      pkt_cnt0_r <= 32'd0;
      pkt_cnt1_r <= 32'd0;
    end else if (rst_cntrs) begin
      pkt_cnt0_r <= 32'd0;
      pkt_cnt1_r <= 32'd0;
    end else begin
      if (done0_s) begin
        pkt_cnt0_r <= pkt_cnt0_r + 32'd1;
      end
      if (done1_s) begin
        pkt_cnt1_r <= pkt_cnt1_r + 32'd1;
      end
    end
  end

  assign pkt_cnt0   = pkt_cnt0_r;
  assign pkt_cnt1   = pkt_cnt1_r;
  assign burst_done = burst_done_r;
  assign busy       = busy_r;

endmodule
